// File: rtl/video_dsm_pkg.sv
// Shared widths, clamp limits, FSM encoding and LFSR taps for the
// composite-video delta-sigma DAC.
package video_dsm_pkg;

    localparam int C_VW = 6;   // video code width
    localparam int C_FW = 2;   // dither width
    localparam int C_AW = 8;   // accumulator width
    localparam int C_LW = 16;  // LFSR width

    localparam logic [C_VW-1:0] C_CLAMP_LO = 6'd0;
    localparam logic [C_VW-1:0] C_CLAMP_HI = 6'd63;

    // x^16 + x^14 + x^13 + x^11 + 1, left-shifting form (state bits 15,13,12,10)
    localparam logic [C_LW-1:0] C_LFSR_TAPS = 16'hB400;

    typedef enum logic {
        ST_MUTE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/video_dsm_lfsr.sv
// 16-bit Fibonacci LFSR used as the modulator dither source.
// Only instantiated when VIDEO_DSM_DITHER_EN is defined.
module video_dsm_lfsr
    import video_dsm_pkg::*;
#(
    parameter logic [C_LW-1:0] C_SEED = 16'hACE1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            en_i,
    output logic [C_LW-1:0] state_o
);

    logic [C_LW-1:0] lfsr_q, lfsr_d;
    logic            fb;

    always_comb begin
        fb     = ^(lfsr_q & C_LFSR_TAPS);
        lfsr_d = lfsr_q;
        if (en_i) begin
            lfsr_d = {lfsr_q[C_LW-2:0], fb};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= C_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state_o = lfsr_q;

endmodule

// File: rtl/video_dsm_dac.sv
// Video code -> gain/offset trim with saturation -> first-order delta-sigma bitstream.
// Optional dither from an LFSR when VIDEO_DSM_DITHER_EN is defined.
module video_dsm_dac
    import video_dsm_pkg::*;
#(
    parameter logic [4:0]        C_GAIN      = 5'd16,
    parameter logic signed [5:0] C_OFS       = 6'sd0,
    parameter logic [3:0]        C_MUTE_FR   = 4'd2,
    parameter logic [C_LW-1:0]   C_LFSR_SEED = 16'hACE1
) (
    input  logic            CK_i,
    input  logic            RST_i,
    input  logic            CK_EE_i,
    input  logic [C_VW-1:0] VIDEOs_i,
    input  logic            HVcy_i,
    output logic            DAC_o,
    output logic            MUTE_o,
    output logic            SAT_o
);

    logic [C_VW-1:0] samp_q, samp_d;
    logic [C_VW-1:0] prev_q, prev_d;
    logic [C_VW-1:0] x_q, x_d;
    logic            sat_q, sat_d;
    logic [C_AW-1:0] acc_q, acc_d;
    logic            c_q, c_d;
    logic            dac_q, dac_d;
    state_e          state_q, state_d;
    logic [3:0]      frctr_q, frctr_d;
    logic            mute_q, mute_d;

    logic [10:0]     prod;
    logic [6:0]      p;
    logic signed [8:0] t;
    logic            clamp;
    logic [C_VW-1:0] xm;
    logic [C_FW-1:0] dith;
    logic [C_AW:0]   acc_sum;
    logic            hv;

    // s1: capture the pixel-rate sample
    always_comb begin
        samp_d = samp_q;
        if (CK_EE_i) begin
            samp_d = VIDEOs_i;
        end
        prev_d = samp_q;
    end

    // s2: trim and clamp; SAT fires only when a changed sample clamps
    always_comb begin
        prod  = {5'b0, samp_q} * {6'b0, C_GAIN};
        p     = 7'(prod >> 4);
        t     = $signed({2'b00, p}) + $signed({{3{C_OFS[5]}}, C_OFS});
        clamp = 1'b0;
        x_d   = t[C_VW-1:0];
        if (t < 9'sd0) begin
            x_d   = C_CLAMP_LO;
            clamp = 1'b1;
        end else if (t > 9'sd63) begin
            x_d   = C_CLAMP_HI;
            clamp = 1'b1;
        end
        sat_d = clamp && (samp_q != prev_q);
    end

    // FSM next state
    assign hv = HVcy_i && CK_EE_i;

    always_comb begin
        state_d = state_q;
        frctr_d = frctr_q;
        case (state_q)
            ST_MUTE: begin
                if (C_MUTE_FR == 4'd0) begin
                    state_d = ST_RUN;
                end else if (hv) begin
                    frctr_d = frctr_q + 4'd1;
                    if (frctr_q == C_MUTE_FR - 4'd1) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_MUTE;
        endcase
    end

    // FSM outputs: MUTE_o tracks the next state so it lands with the state flop
    always_comb begin
        mute_d = (state_d != ST_RUN);
        xm     = (state_q == ST_RUN) ? x_q : '0;
    end

`ifdef VIDEO_DSM_DITHER_EN
    logic [C_LW-1:0] lfsr_state;
    logic            unused_lfsr_hi;

    video_dsm_lfsr #(
        .C_SEED (C_LFSR_SEED)
    ) u_lfsr (
        .clk_i   (CK_i),
        .rst_i   (RST_i),
        .en_i    (1'b1),
        .state_o (lfsr_state)
    );

    assign unused_lfsr_hi = ^lfsr_state[C_LW-1:C_FW];
    // muted output must stay exactly 0, so dither is gated by state
    assign dith = (state_q == ST_RUN) ? lfsr_state[C_FW-1:0] : '0;
`else
    logic unused_seed;
    assign unused_seed = ^C_LFSR_SEED;
    assign dith        = '0;
`endif

    // s3: first-order modulator; carry out is the bitstream
    always_comb begin
        acc_sum = {1'b0, acc_q} + {1'b0, xm, 2'b00} + {{(C_AW+1-C_FW){1'b0}}, dith};
        acc_d   = acc_sum[C_AW-1:0];
        c_d     = acc_sum[C_AW];
        dac_d   = c_q;
    end

    always_ff @(posedge CK_i) begin
        if (RST_i) begin
            samp_q  <= '0;
            prev_q  <= '0;
            x_q     <= '0;
            sat_q   <= 1'b0;
            acc_q   <= '0;
            c_q     <= 1'b0;
            dac_q   <= 1'b0;
            state_q <= ST_MUTE;
            frctr_q <= '0;
            mute_q  <= 1'b1;
        end else begin
            samp_q  <= samp_d;
            prev_q  <= prev_d;
            x_q     <= x_d;
            sat_q   <= sat_d;
            acc_q   <= acc_d;
            c_q     <= c_d;
            dac_q   <= dac_d;
            state_q <= state_d;
            frctr_q <= frctr_d;
            mute_q  <= mute_d;
        end
    end

    assign DAC_o  = dac_q;
    assign MUTE_o = mute_q;
    assign SAT_o  = sat_q;

endmodule
